// File: rtl/rf_pkg.sv
// Shared constants for the register-file writeback path.
// Widths, depth and writeback source indices.
package rf_pkg;

    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_DEPTH    = 32;
    localparam int RF_ZERO_REG = 0;

    localparam int SRC_ALU = 0;
    localparam int SRC_MC  = 1;

endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter.
// LAST remembers the previous winner; grants are gated off in reset.
module rr_arb2
    import rf_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [1:0] REQ,
    output logic [1:0] GNT
);

    logic last;

    // Grant the lone requester, or the one that did not win last time.
    always_comb begin
        GNT = '0;
        if (RESET_N) begin
            if (REQ[SRC_ALU] && (!REQ[SRC_MC] || last)) begin
                GNT[SRC_ALU] = 1'b1;
            end else if (REQ[SRC_MC]) begin
                GNT[SRC_MC] = 1'b1;
            end
        end
    end

    // Track the most recent winner; hold when idle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            last <= 1'b1;
        end else if (GNT[SRC_ALU]) begin
            last <= 1'b0;
        end else if (GNT[SRC_MC]) begin
            last <= 1'b1;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the register file write port.
// Registered write outputs plus a pending-write scoreboard.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 S0_REQ,
    input  logic [ADDR_W-1:0]    S0_ADDR,
    input  logic [DATA_W-1:0]    S0_DATA,
    output logic                 S0_GNT,
    input  logic                 S1_REQ,
    input  logic [ADDR_W-1:0]    S1_ADDR,
    input  logic [DATA_W-1:0]    S1_DATA,
    output logic                 S1_GNT,
    input  logic                 RSV_EN,
    input  logic [ADDR_W-1:0]    RSV_ADDR,
    input  logic [ADDR_W-1:0]    CHK_ADDR1,
    input  logic [ADDR_W-1:0]    CHK_ADDR2,
    output logic                 HAZARD,
    output logic [2**ADDR_W-1:0] BUSY,
    output logic                 RF_WE,
    output logic [ADDR_W-1:0]    RF_WDA,
    output logic [DATA_W-1:0]    RF_WD
);

    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(RF_ZERO_REG);

    logic [1:0]          gnt;
    logic                any_gnt;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic [2**ADDR_W-1:0] busy_nxt;

    rr_arb2 u_arb (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .REQ     ({S1_REQ, S0_REQ}),
        .GNT     (gnt)
    );

    assign S0_GNT  = gnt[SRC_ALU];
    assign S1_GNT  = gnt[SRC_MC];
    assign any_gnt = |gnt;

    // Route the winning source's address and data.
    always_comb begin
        sel_addr = S0_ADDR;
        sel_data = S0_DATA;
        if (gnt[SRC_MC]) begin
            sel_addr = S1_ADDR;
            sel_data = S1_DATA;
        end
    end

    // Latch the granted write; x0 writes are accepted but never enabled.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            RF_WE  <= 1'b0;
            RF_WDA <= '0;
            RF_WD  <= '0;
        end else begin
            RF_WE <= any_gnt && (sel_addr != ZERO);
            if (any_gnt) begin
                RF_WDA <= sel_addr;
                RF_WD  <= sel_data;
            end
        end
    end

    // Commit clears, a new reservation sets and overrides the clear.
    always_comb begin
        busy_nxt = BUSY;
        if (RF_WE) begin
            busy_nxt[RF_WDA] = 1'b0;
        end
        if (RSV_EN && (RSV_ADDR != ZERO)) begin
            busy_nxt[RSV_ADDR] = 1'b1;
        end
        busy_nxt[RF_ZERO_REG] = 1'b0;
    end

    // Scoreboard state.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            BUSY <= '0;
        end else begin
            BUSY <= busy_nxt;
        end
    end

    assign HAZARD = BUSY[CHK_ADDR1] | BUSY[CHK_ADDR2];

endmodule
